// File: rtl/spike_aer_encoder_if.sv
// Address-event output channel: head event of the encoder FIFO toward the IO stage.
// Latency: none, pure signal bundle.
// Backpressure: valid/ready; the producer holds addr/ts stable while valid & !ready.
interface spike_aer_encoder_if #(
    parameter int ADDR_W = 3,
    parameter int TS_W   = 8
);
    logic              ev_valid;
    logic              ev_ready;
    logic [ADDR_W-1:0] ev_addr;
    logic [TS_W-1:0]   ev_ts;

    modport master (output ev_valid, output ev_addr, output ev_ts, input ev_ready);
    modport slave  (input ev_valid, input ev_addr, input ev_ts, output ev_ready);
endinterface

// File: rtl/spike_aer_encoder.sv
// Serialises neuron spike pulses into {addr, timestep} AER events via round-robin arbiter + event FIFO.
// Latency: spike sampled at edge k, FIFO write at edge k+1, ev_valid visible after k+1 (2 cycles).
// Backpressure: FIFO full stalls the arbiter; pending spikes hold, re-spikes on pending neurons are dropped and counted.
module spike_aer_encoder #(
    parameter int N_NEURONS  = 8,
    parameter int ADDR_W     = $clog2(N_NEURONS),
    parameter int TS_W       = 8,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_NEURONS-1:0]          spike_in,
    input  logic                          tick,
    spike_aer_encoder_if.master           ev,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    drop_cnt
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [TS_W-1:0]   ts;
    } ev_t;

    logic [N_NEURONS-1:0] pend;
    logic [N_NEURONS-1:0] pend_nxt;
    logic [N_NEURONS-1:0] grant;
    logic [N_NEURONS-1:0] collide;
    logic                 grant_vld;
    logic [ADDR_W-1:0]    grant_idx;
    logic [ADDR_W-1:0]    last_grant;
    logic [TS_W-1:0]      ts_cnt;

    ev_t                  mem [FIFO_DEPTH];
    ev_t                  head;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 full;
    logic                 pop;
    logic                 push_ok;

    int                   n_coll;
    int                   drop_sum;
    logic [7:0]           drop_nxt;

    assign full    = (fifo_level == LVL_W'(FIFO_DEPTH));
    assign pop     = ev.ev_valid & ev.ev_ready;
    // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
    assign push_ok = !full | pop;

    // Round-robin search over registered pend, starting one past the last granted neuron.
    always_comb begin
        int idx;
        idx       = 0;
        grant     = '0;
        grant_vld = 1'b0;
        grant_idx = '0;
        if (push_ok) begin
            for (int k = 0; k < N_NEURONS; k++) begin
                idx = int'(last_grant) + 1 + k;
                if (idx >= N_NEURONS) idx = idx - N_NEURONS;
                if (!grant_vld && pend[idx]) begin
                    grant_vld = 1'b1;
                    grant_idx = ADDR_W'(idx);
                end
            end
        end
        if (grant_vld) grant[grant_idx] = 1'b1;
    end

    // A new spike on a still-pending, ungranted neuron has nowhere to go: it is lost.
    assign collide  = spike_in & pend & ~grant;
    assign pend_nxt = (pend & ~grant) | spike_in;

    // Count colliding bits this cycle and saturate the drop counter at 255.
    always_comb begin
        n_coll = 0;
        for (int i = 0; i < N_NEURONS; i++) begin
            if (collide[i]) n_coll = n_coll + 1;
        end
        drop_sum = int'(drop_cnt) + n_coll;
        drop_nxt = (drop_sum > 255) ? 8'hFF : 8'(drop_sum);
    end

    // Control state: pending spikes, timestep, RR pointer, FIFO pointers/level, drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend       <= '0;
            ts_cnt     <= '0;
            last_grant <= ADDR_W'(N_NEURONS - 1);
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            drop_cnt   <= '0;
        end else begin
            pend     <= pend_nxt;
            drop_cnt <= drop_nxt;
            if (tick) ts_cnt <= ts_cnt + TS_W'(1);
            if (grant_vld) begin
                last_grant <= grant_idx;
                wr_ptr     <= wr_ptr + PTR_W'(1);
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            if (grant_vld && !pop)      fifo_level <= fifo_level + LVL_W'(1);
            else if (!grant_vld && pop) fifo_level <= fifo_level - LVL_W'(1);
        end
    end

    // Event storage; timestamp is the pre-increment ts_cnt when tick coincides with the grant.
    always_ff @(posedge clk) begin
        if (grant_vld) mem[wr_ptr] <= '{addr: grant_idx, ts: ts_cnt};
    end

    // First-word-fall-through head; stale memory contents are masked to zero while empty.
    always_comb begin
        head        = mem[rd_ptr];
        ev.ev_valid = (fifo_level != '0);
        ev.ev_addr  = ev.ev_valid ? head.addr : '0;
        ev.ev_ts    = ev.ev_valid ? head.ts   : '0;
    end
endmodule
